// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan driver.
//   DIGIT_BLANK   digit code that renders as an unlit digit
//   SEG_BLANK     active-high glyph for blank
//   SEG_DASH      active-high glyph for codes 11..15
//   SEG_GLYPH     active-high glyphs for numerals 0..9, {dp,g,f,e,d,c,b,a}
//   fnd_state_e   scan FSM states
package fnd_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'd10;
  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DASH    = 8'h40;

  // Element [n] is the glyph for numeral n.
  localparam logic [9:0][7:0] SEG_GLYPH = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } fnd_state_e;

endpackage

// File: rtl/fnd_seg_decode.sv
// Digit code to seven-segment glyph, purely combinational, active-high.
//   i_code  4-bit digit code (0-9 numeral, 10 blank, 11-15 dash)
//   o_seg   {dp,g,f,e,d,c,b,a}; dp is never lit
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_code < 4'd10)            o_seg = SEG_GLYPH[i_code];
    else if (i_code == DIGIT_BLANK) o_seg = SEG_BLANK;
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed driver for a 4-digit seven-segment display.
// Each slot lasts CLK_HZ/SCAN_HZ cycles: DEAD_CYCLES with every common off,
// then the slot's digit lit. All four digit codes are captured together at
// the start of a frame so a frame never mixes two scores.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              display enable; low blanks pins and parks scan at frame start
//   i_digit_one..thou digit codes, units .. thousands
//   i_blink           blink request (only with FND_BLINK_EN)
//   o_fnd_com         commons, bit0 = units
//   o_fnd_seg         segments {dp,g,f,e,d,c,b,a}
//   o_frame_tick      one-cycle pulse on the cycle the snapshot is taken
// Optional feature macro: FND_BLINK_EN (blink counter + i_blink port).
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int DEAD_CYCLES = 64,
  parameter int COM_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 1
`ifdef FND_BLINK_EN
  ,
  parameter int BLINK_HZ    = 2
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_digit_one,
  input  logic [3:0] i_digit_ten,
  input  logic [3:0] i_digit_hun,
  input  logic [3:0] i_digit_thou,
`ifdef FND_BLINK_EN
  input  logic       i_blink,
`endif
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_seg,
  output logic       o_frame_tick
);

  localparam int              DIV     = CLK_HZ / SCAN_HZ;
  localparam int              CW      = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]   DEAD_C  = CW'(DEAD_CYCLES);
  localparam logic [3:0]      COM_OFF = (COM_ACT_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [7:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  fnd_state_e      state_q, state_d;
  logic [3:0][3:0] snap_q;
  logic [3:0]      com_q, com_d;
  logic [7:0]      seg_q, seg_d;
  logic [7:0]      glyph;
  logic            frame_start;
  logic            blink_off;

  // Frame start also covers the first enabled cycle after i_en was low,
  // because a low enable parks the scan at cnt 0 / digit 0.
  assign frame_start  = i_en && !i_rst && (cnt_q == '0) && (idx_q == 2'd0);
  assign o_frame_tick = frame_start;

`ifdef FND_BLINK_EN
  localparam int            BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int            BW        = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_q;

  // Free-running; deliberately independent of i_en so blink phase is stable.
  always_ff @(posedge i_clk) begin
    if (i_rst)                               blink_q <= '0;
    else if (blink_q == BW'(BLINK_DIV - 1))  blink_q <= '0;
    else                                     blink_q <= blink_q + 1'b1;
  end

  assign blink_off = i_blink && (blink_q >= BW'(BLINK_DIV / 2));
`else
  assign blink_off = 1'b0;
`endif

  fnd_seg_decode u_dec (
    .i_code (snap_q[idx_q]),
    .o_seg  (glyph)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_DEAD;
    else       state_q <= state_d;
  end

  // Next state: prescaler, digit index and FSM phase derived from the new count
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!i_en) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == DIV_M1) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    state_d = (cnt_d < DEAD_C) ? ST_DEAD : ST_ON;
  end

  // Outputs: computed from this cycle's state, registered below
  always_comb begin
    logic [3:0] com_raw;
    logic [7:0] seg_raw;
    com_raw = 4'h0;
    seg_raw = 8'h00;
    if (i_en && state_q == ST_ON) begin
      com_raw[idx_q] = 1'b1;
      seg_raw        = glyph;
    end
    if (blink_off) com_raw = 4'h0;
    com_d = (COM_ACT_LOW != 0) ? ~com_raw : com_raw;
    seg_d = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= {4{DIGIT_BLANK}};
      com_q  <= COM_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (frame_start) snap_q <= {i_digit_thou, i_digit_hun, i_digit_ten, i_digit_one};
      com_q <= com_d;
      seg_q <= seg_d;
    end
  end

  assign o_fnd_com = com_q;
  assign o_fnd_seg = seg_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] d_one = 4'd3, d_ten = 4'd2, d_hun = 4'd1, d_thou = 4'd10;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_seg;
  logic       o_frame_tick;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fnd_scan_driver #(
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .DEAD_CYCLES (2),
    .COM_ACT_LOW (1),
    .SEG_ACT_LOW (1)
`ifdef FND_BLINK_EN
    ,
    .BLINK_HZ    (10)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_digit_one  (d_one),
    .i_digit_ten  (d_ten),
    .i_digit_hun  (d_hun),
    .i_digit_thou (d_thou),
`ifdef FND_BLINK_EN
    .i_blink      (1'b0),
`endif
    .o_fnd_com    (o_fnd_com),
    .o_fnd_seg    (o_fnd_seg),
    .o_frame_tick (o_frame_tick)
  );

  // Active-low glyph table written out directly.
  function automatic logic [7:0] glyph_al(input logic [3:0] d);
    case (d)
      4'd0: glyph_al = 8'hC0;
      4'd1: glyph_al = 8'hF9;
      4'd2: glyph_al = 8'hA4;
      4'd3: glyph_al = 8'hB0;
      4'd4: glyph_al = 8'h99;
      4'd5: glyph_al = 8'h92;
      4'd6: glyph_al = 8'h82;
      4'd7: glyph_al = 8'hF8;
      4'd8: glyph_al = 8'h80;
      4'd9: glyph_al = 8'h90;
      4'd10: glyph_al = 8'hFF;
      default: glyph_al = 8'hBF;
    endcase
  endfunction

  function automatic logic [3:0] com_al(input int s);
    case (s)
      0: com_al = 4'hE;
      1: com_al = 4'hD;
      2: com_al = 4'hB;
      default: com_al = 4'h7;
    endcase
  endfunction

  // Entered at the negedge of a frame-tick cycle (offset 0); leaves at the
  // negedge of the next frame-tick cycle (offset 40). Pins at offset o show
  // the scan position of offset o-1. Optionally changes the units input at
  // offset 15 to check that the snapshot is held.
  task automatic check_frame(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3,
                             input logic [3:0] new_one, input string nm);
    logic [3:0] dig[4];
    exp_t e;
    logic exp_tick;
    dig = '{d0, d1, d2, d3};
    for (int o = 1; o <= 40; o++) begin
      int s;
      int k;
      s = (o - 1) / 10;
      k = (o - 1) % 10;
      if (k < 2) e = '{com: 4'hF, seg: 8'hFF};
      else       e = '{com: com_al(s), seg: glyph_al(dig[s])};
      sb.push_back(e);
    end
    for (int o = 1; o <= 40; o++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (o_fnd_com !== e.com || o_fnd_seg !== e.seg) begin
        bad++;
        $display("FAIL %s pins o=%0d got com=%h seg=%h want com=%h seg=%h",
                 nm, o, o_fnd_com, o_fnd_seg, e.com, e.seg);
      end
      exp_tick = (o == 40);
      total++;
      if (o_frame_tick !== exp_tick) begin
        bad++;
        $display("FAIL %s tick o=%0d got %b want %b", nm, o, o_frame_tick, exp_tick);
      end
      if (o == 15) d_one = new_one;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (o_fnd_com !== 4'hF || o_fnd_seg !== 8'hFF) begin
      bad++;
      $display("FAIL reset_pins got com=%h seg=%h want com=F seg=FF", o_fnd_com, o_fnd_seg);
    end
    total++;
    if (o_frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick got %b want 0", o_frame_tick);
    end
    rst = 1'b0;
    #1;
    total++;
    if (o_frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL first_tick got %b want 1", o_frame_tick);
    end
  endtask

  task automatic test_scan();
    check_frame(4'd3, 4'd2, 4'd1, 4'd10, 4'd3, "scan");
  endtask

  task automatic test_tearing();
    check_frame(4'd3, 4'd2, 4'd1, 4'd10, 4'd7, "tear_old");
    check_frame(4'd7, 4'd2, 4'd1, 4'd10, 4'd7, "tear_new");
  endtask

  task automatic test_invalid();
    d_one = 4'd13;
    check_frame(4'd13, 4'd2, 4'd1, 4'd10, 4'd13, "invalid");
  endtask

  // Runs from a tick cycle to cnt=5 of digit 2, then disturbs the scan.
  task automatic test_mid_slot(input logic use_rst);
    repeat (25) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         en  = 1'b0;
    // new inputs must be picked up by the restart snapshot
    d_one = 4'd5; d_ten = 4'd0; d_hun = 4'd8; d_thou = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (o_fnd_com !== 4'hF || o_fnd_seg !== 8'hFF || o_frame_tick !== 1'b0) begin
        bad++;
        $display("FAIL %s_dark cyc=%0d got com=%h seg=%h tick=%b want F FF 0",
                 use_rst ? "rst" : "en", i, o_fnd_com, o_fnd_seg, o_frame_tick);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
    #1;
    total++;
    if (o_frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL %s_restart_tick got %b want 1", use_rst ? "rst" : "en", o_frame_tick);
    end
    check_frame(4'd5, 4'd0, 4'd8, 4'd9, 4'd5, use_rst ? "rst_restart" : "en_restart");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_invalid();
    test_mid_slot(1'b0);
    test_mid_slot(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
